motor_driver: RTL and testbench

MOTOR_DRIVER -- requirements
Module: motor_driver

---
 rtl/motor_driver_pkg.sv | 20 ++
 rtl/motor_driver_pwm_ramp_channel.sv | 53 +++++
 rtl/motor_driver.sv | 92 +++++++++
 tb/tb_motor_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/motor_driver_pkg.sv
// Shared encodings for the two-wheel motor driver: steering commands,
// H-bridge direction codes and FSM states.
package motor_driver_pkg;

  typedef enum logic [1:0] {
    CMD_STOP     = 2'b00,
    CMD_RIGHT    = 2'b01,
    CMD_LEFT     = 2'b10,
    CMD_STRAIGHT = 2'b11
  } cmd_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_COAST = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/motor_driver_pwm_ramp_channel.sv
// One wheel: duty register with slew-limited ramp-up (immediate ramp-down),
// registered PWM compare and H-bridge direction.
module pwm_ramp_channel
  import motor_driver_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clear,
  input  logic                i_update,
  input  logic                i_cmp_en,
  input  logic [PWM_BITS-1:0] i_target,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_pwm,
  output logic [1:0]          o_dir
);

  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(RAMP_STEP);

  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS:0]   w_sum;
  logic [PWM_BITS-1:0] w_next;

  // One extra bit so duty+step cannot wrap back under the target.
  assign w_sum = {1'b0, r_duty} + STEP;

  always_comb begin
    w_next = i_target;
    if ((r_duty < i_target) && (w_sum < {1'b0, i_target}))
      w_next = w_sum[PWM_BITS-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty <= '0;
      o_pwm  <= 1'b0;
      o_dir  <= DIR_COAST;
    end else if (i_clear) begin
      r_duty <= '0;
      o_pwm  <= 1'b0;
      o_dir  <= DIR_COAST;
    end else begin
      o_pwm <= i_cmp_en && (i_cnt < r_duty);
      if (i_update) begin
        r_duty <= w_next;
        o_dir  <= (w_next != '0) ? DIR_FWD : DIR_COAST;
      end
    end
  end

endmodule

// File: rtl/motor_driver.sv
// Line-follower motor driver: IDLE/RUN FSM, shared PWM counter and steering
// decode feeding one ramped PWM channel per wheel.
module motor_driver
  import motor_driver_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int DUTY_FAST = 800,
  parameter int DUTY_SLOW = 300,
  parameter int RAMP_STEP = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start_move,
  input  logic [1:0] i_cmd,
  output logic       o_left_pwm,
  output logic       o_right_pwm,
  output logic [1:0] o_left_dir,
  output logic [1:0] o_right_dir,
  output logic       o_running
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [PWM_BITS-1:0] FAST    = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] SLOW    = PWM_BITS'(DUTY_SLOW);

  state_e              r_state;
  logic [PWM_BITS-1:0] r_cnt;
  cmd_e                r_cmd_q;
  cmd_e                w_cmd;
  logic                w_update;
  logic                w_cmp_en;
  logic                w_clear;
  logic [PWM_BITS-1:0] w_tgt_l;
  logic [PWM_BITS-1:0] w_tgt_r;

  // Duties move on the IDLE->RUN edge and on the last count of each period.
  assign w_clear  = !i_start_move;
  assign w_update = i_start_move && ((r_state == ST_IDLE) || (r_cnt == CNT_MAX));
  assign w_cmp_en = i_start_move && (r_state == ST_RUN);
  assign w_cmd    = w_update ? cmd_e'(i_cmd) : r_cmd_q;

  always_comb begin
    w_tgt_l = '0;
    w_tgt_r = '0;
    case (w_cmd)
      CMD_STRAIGHT: begin w_tgt_l = FAST; w_tgt_r = FAST; end
      CMD_LEFT:     begin w_tgt_l = SLOW; w_tgt_r = FAST; end
      CMD_RIGHT:    begin w_tgt_l = FAST; w_tgt_r = SLOW; end
      default:      begin w_tgt_l = '0;   w_tgt_r = '0;   end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cmd_q   <= CMD_STOP;
      o_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start_move) begin
          r_state   <= ST_RUN;
          o_running <= 1'b1;
          r_cmd_q   <= cmd_e'(i_cmd);
        end
        ST_RUN: if (!i_start_move) begin
          r_state   <= ST_IDLE;
          o_running <= 1'b0;
          r_cnt     <= '0;
          r_cmd_q   <= CMD_STOP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_MAX) r_cmd_q <= cmd_e'(i_cmd);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pwm_ramp_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk(clk), .reset(reset), .i_clear(w_clear), .i_update(w_update),
    .i_cmp_en(w_cmp_en), .i_target(w_tgt_l), .i_cnt(r_cnt),
    .o_pwm(o_left_pwm), .o_dir(o_left_dir)
  );

  pwm_ramp_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk(clk), .reset(reset), .i_clear(w_clear), .i_update(w_update),
    .i_cmp_en(w_cmp_en), .i_target(w_tgt_r), .i_cnt(r_cnt),
    .o_pwm(o_right_pwm), .o_dir(o_right_dir)
  );

endmodule

// File: tb/tb_motor_driver.sv
// Bench for motor_driver: per-cycle comparison against a wheel-level model,
// plus literal duty-per-period expectations for the ramp scenarios.
module tb_motor_driver;

  localparam int PB   = 4;
  localparam int FAST = 12;
  localparam int SLOW = 4;
  localparam int STEP = 4;
  localparam int PER  = 1 << PB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_move = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       lpwm, rpwm, run;
  logic [1:0] ldir, rdir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_driver #(.PWM_BITS(PB), .DUTY_FAST(FAST), .DUTY_SLOW(SLOW), .RAMP_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .i_start_move(start_move), .i_cmd(cmd),
    .o_left_pwm(lpwm), .o_right_pwm(rpwm), .o_left_dir(ldir), .o_right_dir(rdir),
    .o_running(run)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Wheel-level model: side 0 = left, 1 = right
  int m_cnt = 0;
  int m_duty[2] = '{0, 0};
  bit m_pwm[2]  = '{0, 0};
  bit m_run = 0;

  function automatic int tgt(input int side, input logic [1:0] c);
    case (c)
      2'b11:   return FAST;
      2'b10:   return (side == 0) ? SLOW : FAST;
      2'b01:   return (side == 0) ? FAST : SLOW;
      default: return 0;
    endcase
  endfunction

  function automatic int ramp(input int d, input int t);
    if (d >= t) return t;
    return (d + STEP < t) ? d + STEP : t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || !start_move) begin
      m_run  <= 1'b0;
      m_cnt  <= 0;
      m_duty <= '{0, 0};
      m_pwm  <= '{0, 0};
    end else if (!m_run) begin
      m_run <= 1'b1;
      m_cnt <= 0;
      m_pwm <= '{0, 0};
      for (int i = 0; i < 2; i++) m_duty[i] <= ramp(0, tgt(i, cmd));
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pwm[i] <= (m_cnt < m_duty[i]);
        if (m_cnt == PER - 1) m_duty[i] <= ramp(m_duty[i], tgt(i, cmd));
      end
      m_cnt <= (m_cnt + 1) % PER;
    end
  end

  always @(negedge clk) begin
    check("running", int'(run), int'(m_run));
    check("left_pwm", int'(lpwm), int'(m_pwm[0]));
    check("right_pwm", int'(rpwm), int'(m_pwm[1]));
    check("left_dir", int'(ldir), (m_duty[0] != 0) ? 2 : 0);
    check("right_dir", int'(rdir), (m_duty[1] != 0) ? 2 : 0);
  end

  // Counts high pwm cycles over one period, aligned to the period's first compare.
  task automatic measure(output int l, output int r);
    l = 0;
    r = 0;
    repeat (PER) begin
      @(negedge clk);
      l += int'(lpwm);
      r += int'(rpwm);
    end
  endtask

  task automatic expect_period(input string name, input int el, input int er);
    int l, r;
    measure(l, r);
    check({name, "_left_duty"}, l, el);
    check({name, "_right_duty"}, r, er);
  endtask

  task automatic start_and_align();
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    int l, r;
    bit found;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_running", int'(run), 0);
    check("rst_pwm", int'({lpwm, rpwm}), 0);
    check("rst_dir", int'({ldir, rdir}), 0);

    // Straight-line ramp
    reset = 1'b0; start_move = 1'b1; cmd = 2'b11;
    start_and_align();
    expect_period("ramp1", 4, 4);
    expect_period("ramp2", 8, 8);
    expect_period("ramp3", 12, 12);
    expect_period("ramp4", 12, 12);
    check("straight_ldir", int'(ldir), 2);

    // Turn left: inner wheel drops immediately
    cmd = 2'b10;
    measure(l, r);
    expect_period("left_turn", 4, 12);
    // Turn right: left ramps back up, right drops
    cmd = 2'b01;
    measure(l, r);
    expect_period("right_turn1", 8, 4);
    expect_period("right_turn2", 12, 4);

    // Back to straight, then a mid-period glitch to stop that must be ignored
    cmd = 2'b11;
    measure(l, r);
    expect_period("restraight", 12, 8);
    l = 0; r = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      l += int'(lpwm);
      r += int'(rpwm);
      if (i == 4) cmd = 2'b00;
      if (i == 7) cmd = 2'b11;
    end
    check("glitch_left_duty", l, 12);
    check("glitch_right_duty", r, 12);
    expect_period("post_glitch", 12, 12);

    // Stop command at a boundary
    cmd = 2'b00;
    measure(l, r);
    expect_period("stop", 0, 0);
    check("stop_running", int'(run), 1);
    check("stop_dir", int'({ldir, rdir}), 0);

    // start_move dropped mid-period
    cmd = 2'b11;
    measure(l, r);
    expect_period("resume", 4, 4);
    found = 0;
    for (int i = 0; i < 2 * PER && !found; i++) begin
      @(negedge clk);
      if (m_cnt == 7) found = 1;
    end
    check("find_cnt7", int'(found), 1);
    start_move = 1'b0;
    @(negedge clk);
    check("drop_running", int'(run), 0);
    check("drop_outputs", int'({lpwm, rpwm, ldir, rdir}), 0);
    start_move = 1'b1;
    start_and_align();
    expect_period("restart", 4, 4);
    expect_period("restart2", 8, 8);
    expect_period("restart3", 12, 12);

    // Asynchronous reset mid-period
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_running", int'(run), 0);
    check("async_rst_outputs", int'({lpwm, rpwm, ldir, rdir}), 0);
    @(negedge clk);
    reset = 1'b0;
    start_and_align();
    expect_period("post_reset", 4, 4);
    expect_period("post_reset2", 8, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
